// File: rtl/mux32_pkg.sv
// Shared definitions for the 32-input mux round-robin arbiter.
package mux32_pkg;

    localparam int N_REQ = 32;
    localparam int SEL_W = 5;

    // FSM encodings; 2'b11 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // All four 8-input banks disabled (active-low enables).
    localparam logic [3:0] BANK_OFF = 4'b1111;

    // Registered output bundle of the arbiter.
    typedef struct packed {
        logic [N_REQ-1:0] gnt;
        logic [SEL_W-1:0] sel;
        logic             valid;
        logic [3:0]       bank_en_n;
        logic             timeout;
    } arb_out_t;

    // 2-to-4 decode of the bank bits of a select, active low.
    function automatic logic [3:0] bank_dec(input logic [SEL_W-1:0] s);
        return ~(4'b0001 << s[4:3]);
    endfunction

endpackage

// File: rtl/rr_pick32.sv
// Rotating-priority picker: first set request at or after ptr, wrapping 31 -> 0.
module rr_pick32
    import mux32_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    // Scan from the lowest priority down so the last hit is the winner.
    always_comb begin
        idx  = ptr;
        cand = '0;
        any  = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin sequencer for one shared 32:1 mux with break-before-make bank enables.
module mux32_rr_arbiter
    import mux32_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic [3:0]       bank_en_n,
    output logic             timeout
);

    localparam arb_out_t OUT_RST = '{gnt: '0, sel: '0, valid: 1'b0,
                                     bank_en_n: BANK_OFF, timeout: 1'b0};

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    arb_out_t          out_q, out_d;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              owner_req;
    logic              hold_end;

    rr_pick32 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_req = req[out_q.sel];
    assign hold_end  = (cnt_q == HOLD_W'(HOLD_MAX - 1));

    // Next-state, pointer, hold counter and next registered outputs.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        out_d.timeout = 1'b0;
        case (state_q)
            // IDLE and the RELEASE dead cycle both arbitrate from the current pointer;
            // outputs are off in both, only the target state differs.
            ST_IDLE, ST_RELEASE: begin
                state_d         = ST_IDLE;
                cnt_d           = '0;
                out_d.valid     = 1'b0;
                out_d.gnt       = '0;
                out_d.bank_en_n = BANK_OFF;
                if (pick_any) begin
                    state_d         = ST_GRANT;
                    out_d.valid     = 1'b1;
                    out_d.gnt       = N_REQ'(1) << pick_idx;
                    out_d.sel       = pick_idx;
                    out_d.bank_en_n = bank_dec(pick_idx);
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + HOLD_W'(1);
                if (done || !owner_req || hold_end) begin
                    state_d         = ST_RELEASE;
                    ptr_d           = out_q.sel + SEL_W'(1);
                    cnt_d           = '0;
                    out_d.valid     = 1'b0;
                    out_d.gnt       = '0;
                    out_d.bank_en_n = BANK_OFF;
                    // A normal release (DONE or withdrawal) wins over the hold limit.
                    out_d.timeout   = !done && owner_req;
                end
            end
            default: begin
                state_d         = ST_IDLE;
                cnt_d           = '0;
                out_d.valid     = 1'b0;
                out_d.gnt       = '0;
                out_d.bank_en_n = BANK_OFF;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            out_q   <= OUT_RST;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign gnt       = out_q.gnt;
    assign sel       = out_q.sel;
    assign valid     = out_q.valid;
    assign bank_en_n = out_q.bank_en_n;
    assign timeout   = out_q.timeout;

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/releases, a monitor checks them.
module tb_mux32_rr_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        done  = 1'b0;
    logic [31:0] req   = '0;
    logic [31:0] gnt;
    logic [4:0]  sel;
    logic        valid;
    logic [3:0]  bank_en_n;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] gnt;
        logic [4:0]  sel;
        logic [3:0]  bank;
        int          gap;   // expected idle cycles before this grant, -1 = don't care
    } g_t;

    typedef struct {
        logic tmo;
        int   len;          // expected number of VALID cycles of the grant
    } r_t;

    g_t gq[$];
    r_t rq[$];

    mux32_rr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .sel       (sel),
        .valid     (valid),
        .bank_en_n (bank_en_n),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_g(input logic [31:0] g, input logic [4:0] s, input logic [3:0] b,
                          input int gap);
        g_t e;
        e.gnt = g; e.sel = s; e.bank = b; e.gap = gap;
        gq.push_back(e);
    endtask

    task automatic push_r(input logic t, input int len);
        r_t e;
        e.tmo = t; e.len = len;
        rq.push_back(e);
    endtask

    // Assert reset between clock edges and check outputs before any edge arrives.
    task automatic do_reset(input string nm);
        #1 rst_n = 1'b0;
        #1;
        chk({nm, "_gnt"},   gnt, 32'h0);
        chk({nm, "_sel"},   {27'h0, sel}, 32'h0);
        chk({nm, "_valid"}, {31'h0, valid}, 32'h0);
        chk({nm, "_bank"},  {28'h0, bank_en_n}, 32'hF);
        chk({nm, "_tmo"},   {31'h0, timeout}, 32'h0);
        tick(2);
        rst_n = 1'b1;
    endtask

    // Monitor: pops an expected grant on VALID rise, an expected release on VALID fall.
    initial begin
        bit   pv;
        int   run;
        int   gap;
        g_t   cg;
        r_t   cr;
        pv  = 1'b0;
        run = 0;
        gap = 1000;
        cg  = '{gnt: '0, sel: '0, bank: '0, gap: -1};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv  = 1'b0;
                run = 0;
                gap = 1000;
            end else begin
                if (valid && !pv) begin
                    if (gq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_grant: got sel %0d expected none", sel);
                    end else begin
                        cg = gq.pop_front();
                        chk("grant_gnt",  gnt, cg.gnt);
                        chk("grant_sel",  {27'h0, sel}, {27'h0, cg.sel});
                        chk("grant_bank", {28'h0, bank_en_n}, {28'h0, cg.bank});
                        chk("grant_tmo",  {31'h0, timeout}, 32'h0);
                        if (cg.gap >= 0) chk("grant_gap", gap, cg.gap);
                    end
                    run = 1;
                end else if (valid) begin
                    chk("hold_gnt", gnt, cg.gnt);
                    chk("hold_sel", {27'h0, sel}, {27'h0, cg.sel});
                    run++;
                end else if (pv) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_release: got len %0d expected none", run);
                    end else begin
                        cr = rq.pop_front();
                        chk("rel_tmo",  {31'h0, timeout}, {31'h0, cr.tmo});
                        chk("rel_len",  run, cr.len);
                        chk("rel_gnt",  gnt, 32'h0);
                        chk("rel_bank", {28'h0, bank_en_n}, 32'hF);
                        chk("rel_sel",  {27'h0, sel}, {27'h0, cg.sel});
                    end
                    gap = 1;
                end else begin
                    chk("idle_tmo",  {31'h0, timeout}, 32'h0);
                    chk("idle_bank", {28'h0, bank_en_n}, 32'hF);
                    gap++;
                end
                pv = valid;
            end
        end
    end

    // Directed stimulus.
    initial begin
        do_reset("rst_init");
        tick(1);

        // Single request on 5, released by DONE after two VALID cycles.
        push_g(32'h0000_0020, 5'd5, 4'b1110, -1);
        push_r(1'b0, 2);
        req = 32'h0000_0020;
        tick(2);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = '0;
        tick(2);

        // Round robin 0/31 with wrap, one dead cycle between grants.
        do_reset("rst_idle");
        tick(1);
        push_g(32'h0000_0001, 5'd0,  4'b1110, -1); push_r(1'b0, 1);
        push_g(32'h8000_0000, 5'd31, 4'b0111,  1); push_r(1'b0, 1);
        push_g(32'h0000_0001, 5'd0,  4'b1110,  1); push_r(1'b0, 1);
        push_g(32'h8000_0000, 5'd31, 4'b0111,  1); push_r(1'b0, 1);
        req = 32'h8000_0001;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            done = 1'b1;
            tick(1);
            done = 1'b0;
        end
        req = '0;
        tick(2);

        // Timeout on 20 after 15 VALID cycles, then sole requester re-granted.
        push_g(32'h0010_0000, 5'd20, 4'b1011, -1); push_r(1'b1, 15);
        push_g(32'h0010_0000, 5'd20, 4'b1011,  1); push_r(1'b0, 1);
        req = 32'h0010_0000;
        tick(16);
        chk("tmo_pulse", {31'h0, timeout}, 32'h1);
        tick(1);
        chk("tmo_cleared", {31'h0, timeout}, 32'h0);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = '0;
        tick(2);

        // DONE on the 15th VALID cycle: normal release, no timeout.
        push_g(32'h0010_0000, 5'd20, 4'b1011, -1); push_r(1'b0, 15);
        req = 32'h0010_0000;
        tick(15);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = '0;
        tick(2);

        // Requester 7 withdraws mid-grant.
        push_g(32'h0000_0080, 5'd7, 4'b1110, -1); push_r(1'b0, 3);
        req = 32'h0000_0080;
        tick(3);
        req = '0;
        tick(3);

        // Reset mid-grant on 9 restores PTR to 0: 3 wins before 9.
        push_g(32'h0000_0200, 5'd9, 4'b1101, -1);
        req = 32'h0000_0200;
        tick(2);
        req = 32'h0000_0208;
        do_reset("rst_grant");
        push_g(32'h0000_0008, 5'd3, 4'b1110, -1); push_r(1'b0, 1);
        push_g(32'h0000_0200, 5'd9, 4'b1101,  1); push_r(1'b0, 1);
        tick(1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tick(1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = '0;
        tick(4);

        chk("grant_q_empty",   gq.size(), 32'h0);
        chk("release_q_empty", rq.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
